// File: rtl/reg_bitmap_renderer.sv
// reg_bitmap_renderer: draws per-frame register snapshots as a bit-cell grid with change highlights; in clk/rst/x/y/frame_start/freeze/registers, out r/g/b/snap_valid
module reg_bitmap_renderer #(
  parameter int NUM_REGS = 11,
  parameter int REG_W = 16,
  parameter int CELL = 8,
  parameter int ORIGIN_X = 200,
  parameter int ORIGIN_Y = 240,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               x,
  input  logic [10:0]               y,
  input  logic                      frame_start,
  input  logic                      freeze,
  input  logic [NUM_REGS*REG_W-1:0] registers,
  output logic [2:0]                r,
  output logic [2:0]                g,
  output logic [2:0]                b,
  output logic                      snap_valid
);
  localparam int CW = $clog2(CELL);
  localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int KW = REG_W > 1 ? $clog2(REG_W) : 1;
  logic [11:0] dx, dy;
  logic act_d, grid_d, bord_d, act_q, grid_q, bord_q, snap_valid_q, bit_s;
  logic [RW-1:0] row_d, row_q;
  logic [KW-1:0] col_d, col_q;
  logic [8:0] rgb_d, rgb_q;
  logic [REG_W-1:0] snap_q [NUM_REGS];
  logic [7:0] age_q [NUM_REGS];
  assign dx = {1'b0, x} - 12'(ORIGIN_X);
  assign dy = {1'b0, y} - 12'(ORIGIN_Y);
  always_comb begin
    act_d = x < 11'(H_ACTIVE) && y < 11'(V_ACTIVE);
    grid_d = !dx[11] && !dy[11] && dx < 12'(REG_W*CELL) && dy < 12'(NUM_REGS*CELL);
    bord_d = dx[CW-1:0] == '0 || dy[CW-1:0] == '0;
    row_d = dy[CW +: RW];
    col_d = dx[CW +: KW];
    bit_s = snap_q[row_q][KW'(REG_W-1) - col_q];
    rgb_d = !(act_q && grid_q && snap_valid_q) ? 9'o000 :
            bord_q ? 9'o222 :
            !bit_s ? 9'o000 :
            age_q[row_q] != 8'd0 ? 9'o700 : 9'o777;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      {act_q, grid_q, bord_q, snap_valid_q} <= '0;
      row_q <= '0;
      col_q <= '0;
      rgb_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      {act_q, grid_q, bord_q} <= {act_d, grid_d, bord_d};
      row_q <= row_d;
      col_q <= col_d;
      rgb_q <= rgb_d;
      if (frame_start && !freeze) begin
        snap_valid_q <= 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
          snap_q[i] <= registers[i*REG_W +: REG_W];
          age_q[i] <= registers[i*REG_W +: REG_W] != snap_q[i] ? 8'(HOLD_FRAMES) :
                      age_q[i] - 8'(age_q[i] != 8'd0);
        end
      end
    end
  end
  assign {r, g, b} = rgb_q;
  assign snap_valid = snap_valid_q;
endmodule

// File: tb/tb_reg_bitmap_renderer.sv
// tb_reg_bitmap_renderer: random and directed checks of the renderer against a behavioural pixel model
module tb_reg_bitmap_renderer;
  localparam int NR = 11, RWD = 16, CELL = 8, OX = 200, OY = 240, HOLD = 30;
  logic clk = 0, rst = 0, frame_start = 0, freeze = 0;
  logic [10:0] x = 0, y = 0;
  logic [NR*RWD-1:0] regs = '0;
  logic [2:0] r, g, b;
  logic snap_valid;
  int checks = 0, errors = 0;
  bit go = 0;
  logic [RWD-1:0] msnap [NR];
  int mage [NR];
  bit mvalid, p1v;
  int px1, py1;
  logic [8:0] exp_rgb;

  reg_bitmap_renderer dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start), .freeze(freeze),
    .registers(regs), .r(r), .g(g), .b(b), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] colour(input int px, input int py);
    int row, col;
    logic [RWD-1:0] v;
    if (px >= 640 || py >= 480) return 9'o000;
    if (px < OX || px >= OX + RWD*CELL || py < OY || py >= OY + NR*CELL) return 9'o000;
    if (!mvalid) return 9'o000;
    if ((px - OX) % CELL == 0 || (py - OY) % CELL == 0) return 9'o222;
    row = (py - OY) / CELL;
    col = (px - OX) / CELL;
    v = msnap[row];
    if (!v[RWD-1-col]) return 9'o000;
    return mage[row] != 0 ? 9'o700 : 9'o777;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      exp_rgb = 0;
      p1v = 0;
      mvalid = 0;
      for (int i = 0; i < NR; i++) begin
        msnap[i] = 0;
        mage[i] = 0;
      end
    end else begin
      exp_rgb = p1v ? colour(px1, py1) : 9'o000;
      px1 = x;
      py1 = y;
      p1v = 1;
      if (frame_start && !freeze) begin
        for (int i = 0; i < NR; i++) begin
          if (regs[i*RWD +: RWD] != msnap[i]) mage[i] = HOLD;
          else if (mage[i] > 0) mage[i]--;
          msnap[i] = regs[i*RWD +: RWD];
        end
        mvalid = 1;
      end
    end
  end

  always @(negedge clk) if (go) begin
    checks++;
    if ({r, g, b} !== exp_rgb || snap_valid !== mvalid) begin
      errors++;
      $display("FAIL model t=%0t: got rgb=%o sv=%b want rgb=%o sv=%b", $time, {r, g, b}, snap_valid, exp_rgb, mvalid);
    end
  end

  task automatic lit(input logic [8:0] want, input logic want_sv, input string nm);
    checks++;
    if ({r, g, b} !== want || snap_valid !== want_sv) begin
      errors++;
      $display("FAIL %s: got rgb=%o sv=%b want rgb=%o sv=%b", nm, {r, g, b}, snap_valid, want, want_sv);
    end
  endtask

  task automatic pix(input int px, input int py, input logic [8:0] want, input string nm);
    x = 11'(px);
    y = 11'(py);
    @(negedge clk);
    @(negedge clk);
    lit(want, 1'b1, nm);
  endtask

  task automatic pulse();
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
  endtask

  initial begin
    @(negedge clk);
    go = 1;
    @(negedge clk);
    lit(9'o000, 1'b0, "reset_state");
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      x = 11'(200 + i*9);
      y = 11'(240 + i*5);
      @(negedge clk);
      lit(9'o000, 1'b0, "no_snapshot_sweep");
    end
    regs[0 +: RWD] = 16'h8000;
    pulse();
    pix(204, 244, 9'o700, "msb_red");
    pix(200, 244, 9'o222, "border_grey");
    pix(212, 244, 9'o000, "zero_bit");
    for (int i = 0; i < 29; i++) pulse();
    pix(204, 244, 9'o700, "age_one_left");
    pulse();
    pix(204, 244, 9'o777, "aged_white");
    regs[0 +: RWD] = 16'h8001;
    pulse();
    pix(204, 244, 9'o700, "rechange_red");
    pix(323, 244, 9'o700, "lsb_red");
    freeze = 1;
    regs[3*RWD +: RWD] = 16'h1234;
    for (int i = 0; i < 5; i++) pulse();
    pix(204, 244, 9'o700, "frozen_age");
    pix(228, 268, 9'o000, "frozen_snap");
    freeze = 0;
    pulse();
    pix(228, 268, 9'o700, "unfrozen_red");
    regs = '1;
    pulse();
    pix(640, 100, 9'o000, "h_blank");
    pix(100, 480, 9'o000, "v_blank");
    pix(327, 327, 9'o700, "last_cell");
    rst = 0;
    @(negedge clk);
    lit(9'o000, 1'b0, "midframe_reset");
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lit(9'o000, 1'b0, "black_after_reset");
    end
    pulse();
    pix(327, 327, 9'o700, "after_reset_snap");
    for (int i = 0; i < 3000; i++) begin
      x = 11'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2047) : $urandom_range(190, 340));
      y = 11'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2047) : $urandom_range(230, 340));
      frame_start = $urandom_range(0, 15) == 0;
      freeze = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 40) == 0) regs[$urandom_range(0, NR-1)*RWD +: RWD] = RWD'($urandom);
      if ($urandom_range(0, 1500) == 0) rst = 0;
      else rst = 1;
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bitmap_renderer.md
Name: reg_bitmap_renderer

Overview:
Parametrised successor to the register-display renderer in the VGA debug path. It draws NUM_REGS registers of REG_W bits as a grid of square bit cells at a configurable origin. Register values are snapshotted once per frame, so the display never tears mid-frame. Rows whose value changed are highlighted red for HOLD_FRAMES frames. Pixel colour is produced through a registered 2-stage pipeline and is fed to the VGA output mux.

Parameters:
NUM_REGS, 11, number of displayed registers (rows)
REG_W, 16, bits per register (columns)
CELL, 8, cell edge in pixels; power of two, 4..32
ORIGIN_X, 200, x of the left edge of the grid
ORIGIN_Y, 240, y of the top edge of the grid
H_ACTIVE, 640, visible width
V_ACTIVE, 480, visible height
HOLD_FRAMES, 30, number of frames the change highlight lasts; 1..255

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low
x  in  11  current pixel column
y  in  11  current pixel row
frame_start  in  1  one-cycle pulse issued in vertical blanking
freeze  in  1  1 = hold the snapshot and highlight ages
registers  in  NUM_REGS*REG_W  live values; register i occupies bits [i*REG_W +: REG_W]
r  out  3  red
g  out  3  green
b  out  3  blue
snap_valid  out  1  1 once the first snapshot has been taken

Behaviour:
- Reset (rst=0 at a clk edge):
  - r, g, b = 0.
  - snap_valid = 0.
  - All snapshot registers = 0.
  - All age counters = 0.
  - Both pipeline stages flushed to a "black" state.
  - Takes effect on the same edge, including mid-frame.
- Snapshot, on a clk edge with frame_start=1 and freeze=0:
  - snap[i] <= registers[i].
  - age[i] <= HOLD_FRAMES if registers[i] != snap[i]; otherwise age[i] <= max(age[i]-1, 0).
  - snap_valid <= 1.
  - The new values are used starting from the next cycle.
- frame_start with freeze=1: snap, age and snap_valid are unchanged.
- The first snapshot after reset compares against 0. Nonzero rows are therefore highlighted.
- Geometry:
  - Grid spans x in [ORIGIN_X, ORIGIN_X+REG_W*CELL) and y in [ORIGIN_Y, ORIGIN_Y+NUM_REGS*CELL).
  - Row = (y-ORIGIN_Y)/CELL, selecting register row.
  - Column c = (x-ORIGIN_X)/CELL. Column 0 shows bit REG_W-1 (MSB left).
  - Local offsets: ox = (x-ORIGIN_X)%CELL, oy likewise. Shift and mask only; no dividers.
- Colour rules, applied in priority order:
  1. x>=H_ACTIVE or y>=V_ACTIVE: 0/0/0.
  2. Outside the grid: 0/0/0.
  3. snap_valid=0: 0/0/0.
  4. ox==0 or oy==0 (cell border): 2/2/2 grey.
  5. Bit=1 and age[row]!=0: 7/0/0.
  6. Bit=1 and age[row]==0: 7/7/7.
  7. Bit=0: 0/0/0.
- Pipeline latency is exactly 2 cycles, from x/y at edge N to rgb valid after edge N+2.
  - Stage 1 registers: active flag, in-grid flag, row, column, border flag.
  - Stage 2 registers: selects the bit from the current snap and age, and registers rgb.
  - No stall; a new pixel is accepted every cycle.
- Arithmetic:
  - Subtractions are done at 12 bits so that x<ORIGIN_X is detected by a sign/compare, never by wrap-around.
  - Row and column are ceil(log2)-wide.
- age saturates at 0.
- A change during an active highlight reloads age to HOLD_FRAMES.
- frame_start and a pixel in the grid on the same cycle is legal. That pixel uses the pre-update snapshot if it is in stage 2 at that edge.

Test Plan:
1. Reset, then rst=1 with no frame_start; sweep (200,240) -> rgb=0 at every pixel and snap_valid=0.
2. registers[0]=16'h8000; pulse frame_start; sample pixel (204,244) -> 7/0/0 exactly 2 cycles after the x/y input. Pixel (200,244) -> 2/2/2. Pixel (212,244) -> 0/0/0.
3. Hold registers constant; issue 30 frame_start pulses -> (204,244) turns 7/7/7 after the 30th pulse. Then change registers[0]=16'h8001 and pulse -> 7/0/0 again, and (323,244) is lit red.
4. freeze=1; change registers[3]; pulse frame_start 5 times -> the display and age are unchanged. freeze=0 plus one pulse -> new value shown in red.
5. x=640,y=100 and x=100,y=480 with all registers 16'hFFFF -> 0/0/0. Pixel (327,327) (last cell, interior) -> lit.
6. Assert rst=0 mid-frame while streaming pixels -> rgb is 0 on the following cycle, snap_valid=0, and it stays black until the next frame_start.
